dpc_bp_report_packer: RTL
=========================

Name: dpc_bp_report_packer

Overview:
- Sits directly downstream of the detector's auto-bad-pixel report port (auto_bp_* / frame_detection_done / detected_bp_count).
- Buffers detected bad-pixel coordinates in a FIFO and packs them into a 32-bit AXI-Stream report per frame for DMA to the host: one header word, N entry words, one trailer word carrying tlast.
- The host merges this report with the manual table and loads the result into the corrector.

Parameters:
- FIFO_DEPTH, 256, entry FIFO depth (power of 2); entries plus frame-end markers.
- FIFO_BIT, 8, log2(FIFO_DEPTH).

Ports:
- axis_aclk  in  1  clock.
- axis_aresetn  in  1  asynchronous active-low reset.
- auto_bp_valid  in  1  detector entry valid.
- auto_bp_x  in  10  entry column.
- auto_bp_y  in  10  entry row.
- auto_bp_type  in  1  0=dead, 1=stuck.
- auto_bp_ready  out  1  entry accept.
- frame_detection_done  in  1  single-cycle pulse, end of frame detection.
- detected_bp_count  in  9  detector's count, valid in the done cycle.
- m_axis_tvalid  out  1  report word valid.
- m_axis_tready  in  1  report word accept.
- m_axis_tdata  out  32  report word.
- m_axis_tlast  out  1  high on trailer word only.
- frame_seq  out  16  number of trailers sent since reset.
- fifo_level  out  FIFO_BIT+1  current FIFO occupancy.
- count_mismatch  out  1  one-cycle pulse when a trailer with mismatch=1 is accepted.

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM IDLE, frame_seq=0, per-frame sent counter=0. Reset mid-frame discards everything, including a partially sent report; no trailer is emitted.

FIFO:
- Width 22 bits: {marker, type, y[9:0], x[9:0]}.
- auto_bp_ready = (fifo_level < FIFO_DEPTH-1) && !frame_detection_done.
- One slot is always reserved, so a marker never finds the FIFO full.
- An entry is pushed when auto_bp_valid && auto_bp_ready (marker=0).
- frame_detection_done pushes a marker {1, 0, 0, detected_bp_count in [8:0]}, regardless of level.
- Done and valid in the same cycle: ready=0, so the marker is pushed first. The held entry is accepted later and belongs to the next frame.
- Simultaneous push and pop are allowed; level is unchanged.

Output word formats:
- Header: [31:28]=4'hA, [27:16]=0, [15:0]=frame_seq.
- Entry: [31:28]=4'h1, [27:21]=0, [20]=type, [19:10]=y, [9:0]=x.
- Trailer: [31:28]=4'hE, [27]=mismatch, [26:18]=0, [17:9]=marker count, [8:0]=entries sent this frame.
- mismatch = (sent != marker count).

FSM (IDLE, HEADER, DATA, TRAILER):
- IDLE: when the FIFO is non-empty, go to HEADER. The output register loads the header and tvalid=1 the next cycle.
- HEADER: on tvalid && tready, go to DATA.
- DATA, head is an entry: pop it, present the entry word, increment sent on acceptance.
- DATA, head is a marker: pop it, latch its count, present the trailer word (tlast=1), go to TRAILER.
- DATA, FIFO empty: tvalid=0 and wait; the frame stays open.
- TRAILER: on acceptance, frame_seq++ (wraps at 16 bits), sent=0, pulse count_mismatch if mismatch=1, then return to IDLE.
- Frame with zero entries: header then trailer, sent=0.

Output handshake:
- m_axis_tdata and m_axis_tlast are registered and held stable while tvalid && !tready.
- No word is dropped or duplicated.
- Back-to-back words at full rate when tready=1 and the FIFO is non-empty.

Latency:
- Entry accepted into an empty FIFO in IDLE at cycle N: header valid at N+1.
- With tready=1 throughout, the entry word is valid at N+2.

Width rules:
- sent saturates at 511; it cannot exceed FIFO_DEPTH per frame unless the report is drained concurrently.

Test Plan:
- Reset, then 3 entries (x=5,y=7,t=0), (639,511,1), (0,0,0), then done with count=3, tready=1 -> stream A0000000, 10001C05, 1017FE7F... (per format), 10000000, E0000603 with tlast; frame_seq=1; count_mismatch stays 0.
- Done pulse with no entries, count=0 -> A000_xxxx header with current seq, then E0000000 with tlast.
- Done with count=5 after 2 entries -> trailer [27]=1, [17:9]=5, [8:0]=2; count_mismatch pulses one cycle on trailer accept.
- Hold tready=0 while 300 entries are offered -> auto_bp_ready falls at fifo_level=255. Then done arrives and its marker fits (level 256). Release tready -> 255 entries and a trailer are sent; the remaining entries go to the next frame.
- auto_bp_valid and frame_detection_done in the same cycle -> ready=0 that cycle; the entry appears after the trailer, under header seq+1.
- Random tready toggling -> tdata/tlast stable while stalled; word sequence matches the reference model; assert axis_aresetn mid-DATA -> tvalid=0 and fifo_level=0 next cycle, frame_seq=0.

Source files
------------

// File: rtl/dpc_bp_report_packer.sv
// Bad-pixel report packer: buffers detector entries and frame-end markers in a FIFO
// and emits one AXI-Stream report per frame (header, entries, trailer with tlast).
module dpc_bp_report_packer #(
    parameter int FIFO_DEPTH = 256,
    parameter int FIFO_BIT   = 8
) (
    input  logic                axis_aclk,
    input  logic                axis_aresetn,
    input  logic                auto_bp_valid,
    input  logic [9:0]          auto_bp_x,
    input  logic [9:0]          auto_bp_y,
    input  logic                auto_bp_type,
    output logic                auto_bp_ready,
    input  logic                frame_detection_done,
    input  logic [8:0]          detected_bp_count,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [31:0]         m_axis_tdata,
    output logic                m_axis_tlast,
    output logic [15:0]         frame_seq,
    output logic [FIFO_BIT:0]   fifo_level,
    output logic                count_mismatch
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_DATA,
        S_TRAILER
    } state_t;

    localparam logic [FIFO_BIT:0] LVL_FULL = (FIFO_BIT + 1)'(FIFO_DEPTH);
    localparam logic [FIFO_BIT:0] LVL_RSV  = (FIFO_BIT + 1)'(FIFO_DEPTH - 1);

    logic [21:0]         r_mem [FIFO_DEPTH];
    logic [FIFO_BIT-1:0] r_wr_ptr;
    logic [FIFO_BIT-1:0] r_rd_ptr;
    logic [FIFO_BIT:0]   r_level;

    state_t              r_state;
    logic                r_tvalid;
    logic [31:0]         r_tdata;
    logic                r_tlast;
    logic [8:0]          r_sent;
    logic [15:0]         r_seq;
    logic                r_mm;

    logic                w_empty;
    logic                w_full;
    logic                w_push_entry;
    logic                w_push_marker;
    logic                w_push;
    logic [21:0]         w_wdata;
    logic [21:0]         w_head;
    logic                w_out_free;
    logic                w_load;
    logic                w_pop;
    logic                w_entry_acc;
    logic [8:0]          w_sent_next;
    logic                w_mismatch;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LVL_FULL);

    // The last slot is held back for the frame-end marker.
    assign auto_bp_ready = axis_aresetn && (r_level < LVL_RSV) && !frame_detection_done;

    assign w_push_entry  = auto_bp_valid && auto_bp_ready;
    assign w_push_marker = frame_detection_done && !w_full;
    assign w_push        = w_push_entry || w_push_marker;
    assign w_wdata       = frame_detection_done
                         ? {1'b1, 1'b0, 10'd0, 1'b0, detected_bp_count}
                         : {1'b0, auto_bp_type, auto_bp_y, auto_bp_x};
    assign w_head        = r_mem[r_rd_ptr];

    // A new word may be loaded once the current one is gone or leaving this cycle.
    assign w_out_free  = !r_tvalid || m_axis_tready;
    assign w_load      = ((r_state == S_HEADER) && m_axis_tready) ||
                         ((r_state == S_DATA) && w_out_free);
    assign w_pop       = w_load && !w_empty;
    assign w_entry_acc = (r_state == S_DATA) && r_tvalid && m_axis_tready;
    assign w_sent_next = (w_entry_acc && (r_sent != 9'h1FF)) ? r_sent + 9'd1 : r_sent;
    assign w_mismatch  = (w_sent_next != w_head[8:0]);

    always_ff @(posedge axis_aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wdata;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_state  <= S_IDLE;
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
            r_sent   <= '0;
            r_seq    <= '0;
            r_mm     <= 1'b0;
        end else begin
            r_mm <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Reacting to the incoming push saves a cycle on the header.
                    if (w_push || !w_empty) begin
                        r_tdata  <= {4'hA, 12'd0, r_seq};
                        r_tlast  <= 1'b0;
                        r_tvalid <= 1'b1;
                        r_state  <= S_HEADER;
                    end
                end
                S_HEADER, S_DATA: begin
                    r_sent <= w_sent_next;
                    if (w_load) begin
                        if (w_empty) begin
                            r_tvalid <= 1'b0;
                            r_state  <= S_DATA;
                        end else if (w_head[21]) begin
                            r_tdata  <= {4'hE, w_mismatch, 9'd0, w_head[8:0], w_sent_next};
                            r_tlast  <= 1'b1;
                            r_tvalid <= 1'b1;
                            r_state  <= S_TRAILER;
                        end else begin
                            r_tdata  <= {4'h1, 7'd0, w_head[20], w_head[19:10], w_head[9:0]};
                            r_tlast  <= 1'b0;
                            r_tvalid <= 1'b1;
                            r_state  <= S_DATA;
                        end
                    end
                end
                S_TRAILER: begin
                    if (m_axis_tready) begin
                        r_tvalid <= 1'b0;
                        r_tlast  <= 1'b0;
                        r_seq    <= r_seq + 16'd1;
                        r_sent   <= '0;
                        r_mm     <= r_tdata[27];
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign m_axis_tvalid  = r_tvalid;
    assign m_axis_tdata   = r_tdata;
    assign m_axis_tlast   = r_tlast;
    assign frame_seq      = r_seq;
    assign fifo_level     = r_level;
    assign count_mismatch = r_mm;

endmodule
